// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman game blocks.
package hangman_pkg;

    typedef enum logic [1:0] {
        ENTRY,
        WAIT_RDY,
        SEND,
        LOCKED
    } game_state_t;

    localparam int         WORD_LEN_DEF = 5;
    localparam logic [7:0] ASCII_A      = 8'h41;
    localparam logic [7:0] ASCII_Z      = 8'h5A;
    localparam logic [7:0] CASE_OFFSET  = 8'h20;

endpackage

// File: rtl/letter_normalizer.sv
// Maps a keypad ASCII code to its upper-case letter and flags whether it is a letter at all.
module letter_normalizer
    import hangman_pkg::*;
(
    input  logic [7:0] code,
    output logic [7:0] upper,
    output logic       ok
);

    always_comb begin
        upper = code;
        ok    = 1'b0;
        if (code >= ASCII_A && code <= ASCII_Z) begin
            ok = 1'b1;
        end else if (code >= (ASCII_A + CASE_OFFSET) && code <= (ASCII_Z + CASE_OFFSET)) begin
            upper = code - CASE_OFFSET;
            ok    = 1'b1;
        end
    end

endmodule

// File: rtl/word_setter.sv
// Secret-word entry for the hangman game: collects letters from the host keypad,
// hands the finished word to the game logic and holds it for the whole round.
module word_setter
    import hangman_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic [7:0]            key_letter,
    input  logic                  key_valid,
    input  logic                  key_del,
    input  logic                  key_confirm,
    input  logic                  game_rdy,
    input  logic                  game_done,
    output logic [8*WORD_LEN-1:0] setWord,
    output logic                  toggle_state,
    output logic [2:0]            letter_count,
    output logic                  word_full,
    output logic                  locked,
    output logic                  key_err
);

    game_state_t           state, state_next;
    logic [8*WORD_LEN-1:0] word, word_next;
    logic [2:0]            count, count_next;
    logic                  err_next;
    logic [7:0]            upper;
    logic                  letter_ok;
    int                    wr_pos;
    int                    del_pos;

    letter_normalizer u_norm (
        .code  (key_letter),
        .upper (upper),
        .ok    (letter_ok)
    );

    assign word_full    = (count == 3'(WORD_LEN));
    assign letter_count = count;
    assign setWord      = word;
    assign toggle_state = (state == SEND);
    assign locked       = (state == SEND) || (state == LOCKED);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= ENTRY;
            word    <= '0;
            count   <= '0;
            key_err <= 1'b0;
        end else begin
            state   <= state_next;
            word    <= word_next;
            count   <= count_next;
            key_err <= err_next;
        end
    end

    // Letter 0 sits in the top byte, so slot n starts 8*(WORD_LEN-1-n) bits up.
    always_comb begin
        state_next = state;
        word_next  = word;
        count_next = count;
        err_next   = 1'b0;
        wr_pos     = 8 * (WORD_LEN - 1 - int'(count));
        del_pos    = 8 * (WORD_LEN - int'(count));
        case (state)
            ENTRY: begin
                if (key_confirm) begin
                    if (!word_full)    err_next   = 1'b1;
                    else if (game_rdy) state_next = SEND;
                    else               state_next = WAIT_RDY;
                end else if (key_del) begin
                    if (count == 3'd0) begin
                        err_next = 1'b1;
                    end else begin
                        word_next[del_pos +: 8] = 8'h00;
                        count_next              = count - 3'd1;
                    end
                end else if (key_valid) begin
                    if (!letter_ok || word_full) begin
                        err_next = 1'b1;
                    end else begin
                        word_next[wr_pos +: 8] = upper;
                        count_next             = count + 3'd1;
                    end
                end
            end
            WAIT_RDY: begin
                if (game_rdy)                     state_next = SEND;
                else if (key_del && !key_confirm) state_next = ENTRY;
            end
            SEND: begin
                state_next = LOCKED;
            end
            LOCKED: begin
                if (game_done) begin
                    word_next  = '0;
                    count_next = '0;
                    state_next = ENTRY;
                end
            end
            default: begin
                state_next = ENTRY;
            end
        endcase
    end

endmodule

// File: tb/tb_word_setter.sv
// Directed self-checking bench for word_setter; expected values are hand-computed ASCII words.
module tb_word_setter;

    logic        tb_clk;
    logic        tb_nrst;
    logic [7:0]  key_letter;
    logic        key_valid;
    logic        key_del;
    logic        key_confirm;
    logic        game_rdy;
    logic        game_done;
    logic [39:0] set_word;
    logic        toggle_state;
    logic [2:0]  letter_count;
    logic        word_full;
    logic        locked;
    logic        key_err;

    int vectors     = 0;
    int miscompares = 0;

    word_setter #(.WORD_LEN(5)) dut (
        .clk          (tb_clk),
        .nRst         (tb_nrst),
        .key_letter   (key_letter),
        .key_valid    (key_valid),
        .key_del      (key_del),
        .key_confirm  (key_confirm),
        .game_rdy     (game_rdy),
        .game_done    (game_done),
        .setWord      (set_word),
        .toggle_state (toggle_state),
        .letter_count (letter_count),
        .word_full    (word_full),
        .locked       (locked),
        .key_err      (key_err)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Holds the strobes for exactly one rising edge, then returns 1 time unit after it.
    task automatic applyStimulus(input logic [7:0] letter, input logic valid, input logic del,
                                 input logic confirm, input logic done);
        key_letter  = letter;
        key_valid   = valid;
        key_del     = del;
        key_confirm = confirm;
        game_done   = done;
        @(posedge tb_clk);
        #1;
        key_letter  = 8'h00;
        key_valid   = 1'b0;
        key_del     = 1'b0;
        key_confirm = 1'b0;
        game_done   = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic typeWord(input string s);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(s[i], 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("no_err_while_typing", {63'd0, key_err}, 64'd0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_word"},   {24'd0, set_word}, 64'd0);
        checkOutput({tag, "_count"},  {61'd0, letter_count}, 64'd0);
        checkOutput({tag, "_toggle"}, {63'd0, toggle_state}, 64'd0);
        checkOutput({tag, "_locked"}, {63'd0, locked}, 64'd0);
        checkOutput({tag, "_err"},    {63'd0, key_err}, 64'd0);
    endtask

    initial begin
        tb_nrst     = 1'b0;
        key_letter  = 8'h00;
        key_valid   = 1'b0;
        key_del     = 1'b0;
        key_confirm = 1'b0;
        game_rdy    = 1'b0;
        game_done   = 1'b0;

        #3;
        checkAllZero("reset");
        idleCycle();
        idleCycle();
        tb_nrst = 1'b1;
        idleCycle();

        // APPLE, immediate hand-off with game_rdy already high
        game_rdy = 1'b1;
        typeWord("APPLE");
        checkOutput("apple_count", {61'd0, letter_count}, 64'd5);
        checkOutput("apple_full", {63'd0, word_full}, 64'd1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("apple_toggle", {63'd0, toggle_state}, 64'd1);
        checkOutput("apple_locked", {63'd0, locked}, 64'd1);
        checkOutput("apple_word", {24'd0, set_word}, 64'h4150504C45);
        applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("apple_toggle_once", {63'd0, toggle_state}, 64'd0);
        checkOutput("locked_still", {63'd0, locked}, 64'd1);
        checkOutput("locked_key_no_err", {63'd0, key_err}, 64'd0);
        checkOutput("locked_word_held", {24'd0, set_word}, 64'h4150504C45);
        checkOutput("locked_count_held", {61'd0, letter_count}, 64'd5);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkAllZero("done");

        // lower-case entry, then deletes and a simultaneous valid+del
        game_rdy = 1'b0;
        typeWord("moore");
        checkOutput("moore_word", {24'd0, set_word}, 64'h4D4F4F5245);
        checkOutput("moore_count", {61'd0, letter_count}, 64'd5);
        for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("del3_word", {24'd0, set_word}, 64'h4D4F000000);
        checkOutput("del3_count", {61'd0, letter_count}, 64'd2);
        applyStimulus(8'h51, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("valid_del_count", {61'd0, letter_count}, 64'd1);
        checkOutput("valid_del_word", {24'd0, set_word}, 64'h4D00000000);
        checkOutput("valid_del_no_err", {63'd0, key_err}, 64'd0);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("del_at_zero_err", {63'd0, key_err}, 64'd1);
        checkOutput("del_at_zero_count", {61'd0, letter_count}, 64'd0);
        idleCycle();
        checkOutput("err_one_cycle", {63'd0, key_err}, 64'd0);

        // A, '1', B, del, confirm with a short word
        applyStimulus(8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h31, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("digit_err", {63'd0, key_err}, 64'd1);
        checkOutput("digit_count", {61'd0, letter_count}, 64'd1);
        applyStimulus(8'h42, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("b_word", {24'd0, set_word}, 64'h4142000000);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("short_confirm_err", {63'd0, key_err}, 64'd1);
        checkOutput("short_count", {61'd0, letter_count}, 64'd1);
        checkOutput("short_word", {24'd0, set_word}, 64'h4100000000);
        checkOutput("short_not_locked", {63'd0, locked}, 64'd0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("done_in_entry_ignored", {61'd0, letter_count}, 64'd1);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // HELLO with delayed game_rdy, including a cancel from WAIT_RDY
        typeWord("HELLO");
        applyStimulus(8'h58, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("full_key_err", {63'd0, key_err}, 64'd1);
        checkOutput("full_key_count", {61'd0, letter_count}, 64'd5);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("cancel_count", {61'd0, letter_count}, 64'd5);
        checkOutput("cancel_no_err", {63'd0, key_err}, 64'd0);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("cancel_back_in_entry", {61'd0, letter_count}, 64'd4);
        applyStimulus(8'h4F, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) applyStimulus(8'h41, 1'b1, 1'b0, 1'b1, 1'b0);
            else idleCycle();
            checkOutput("wait_no_toggle", {63'd0, toggle_state}, 64'd0);
            checkOutput("wait_no_err", {63'd0, key_err}, 64'd0);
        end
        game_rdy = 1'b1;
        idleCycle();
        checkOutput("rdy_toggle", {63'd0, toggle_state}, 64'd1);
        checkOutput("hello_word", {24'd0, set_word}, 64'h48454C4C4F);
        idleCycle();
        checkOutput("rdy_toggle_once", {63'd0, toggle_state}, 64'd0);
        checkOutput("rdy_locked", {63'd0, locked}, 64'd1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkAllZero("hello_done");

        // asynchronous reset while waiting for the game
        game_rdy = 1'b0;
        typeWord("WORDS");
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        tb_nrst = 1'b0;
        #1;
        checkAllZero("async_reset");
        game_rdy = 1'b1;
        idleCycle();
        idleCycle();
        tb_nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            checkOutput("post_reset_no_toggle", {63'd0, toggle_state}, 64'd0);
            checkOutput("post_reset_unlocked", {63'd0, locked}, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/word_setter.md
WORD_SETTER -- requirements
Module: word_setter

Interface
REQ-001 SHALL have parameter WORD_LEN, default 5, letters per secret word; setWord width = 8*WORD_LEN.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port nRst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port key_letter  input  8  ASCII code from host keypad.
REQ-005 SHALL have port key_valid  input  1  one-cycle strobe, key_letter valid.
REQ-006 SHALL have port key_del  input  1  one-cycle strobe, delete last letter / cancel pending send.
REQ-007 SHALL have port key_confirm  input  1  one-cycle strobe, host confirms word.
REQ-008 SHALL have port game_rdy  input  1  game logic able to accept a new word.
REQ-009 SHALL have port game_done  input  1  one-cycle strobe, round finished (win or 6 mistakes).
REQ-010 SHALL have port setWord  output  40  packed word, letter 0 in [39:32], letter 4 in [7:0].
REQ-011 SHALL have port toggle_state  output  1  one-cycle pulse handing word to game logic.
REQ-012 SHALL have port letter_count  output  3  letters currently entered, 0..5.
REQ-013 SHALL have port word_full  output  1  letter_count == WORD_LEN.
REQ-014 SHALL have port locked  output  1  word handed off, round in progress.
REQ-015 SHALL have port key_err  output  1  one-cycle pulse, rejected key.

Function
REQ-016 SHALL implement states ENTRY, WAIT_RDY, SEND, LOCKED.
REQ-017 SHALL, in ENTRY on key_valid, accept 0x41-0x5A as-is and 0x61-0x7A minus 0x20, storing at slot letter_count and incrementing it, registered next cycle.
REQ-018 SHALL pulse key_err one cycle after key_valid with any other code, or with word_full; word and count unchanged.
REQ-019 SHALL, in ENTRY on key_del with letter_count>0, clear the last slot to 0x00 and decrement; at count 0 pulse key_err.
REQ-020 SHALL, in ENTRY on key_confirm with word_full low, pulse key_err and stay in ENTRY.
REQ-021 SHALL, on key_confirm with word_full high, go to SEND if game_rdy high that cycle, else WAIT_RDY.
REQ-022 SHALL, in WAIT_RDY, go to SEND when game_rdy high; key_del returns to ENTRY with word intact; key_valid/key_confirm ignored, no error.
REQ-023 SHALL assert toggle_state for exactly the single cycle spent in SEND, then enter LOCKED.
REQ-024 SHALL hold setWord stable from SEND through LOCKED; all keys ignored in LOCKED, no key_err.
REQ-025 SHALL, on game_done in LOCKED, clear setWord and letter_count to 0 and return to ENTRY next cycle; game_done elsewhere ignored.
REQ-026 SHALL resolve simultaneous strobes by priority key_confirm > key_del > key_valid; lower-priority strobes dropped silently.
REQ-027 SHALL drive locked high in SEND and LOCKED only; word_full combinational from letter_count.

Reset
REQ-028 SHALL, on nRst low at any time including mid-WAIT_RDY or LOCKED, immediately force state ENTRY, setWord 0, letter_count 0, toggle_state 0, key_err 0, locked 0.
REQ-029 SHALL ignore all inputs while nRst low and resume on the first rising clk after release.

Structure
REQ-030 SHALL take state enum, WORD_LEN default and ASCII bounds (A=0x41, Z=0x5A, case offset 0x20) from shared package hangman_pkg.
REQ-031 SHALL place case normalisation and validity check in combinational sub-module letter_normalizer (in: code[7:0]; out: upper[7:0], ok).

Verification
REQ-032 SHALL cover: reset, keys A,P,P,L,E, confirm with game_rdy=1 -> setWord=0x4150504C45, single toggle_state pulse, locked=1.
REQ-033 SHALL cover: keys m,o,o,r,e -> setWord=0x4D4F4F5245, letter_count=5, no key_err.
REQ-034 SHALL cover: keys A,'1',B, del, confirm -> key_err on '1' and on confirm, letter_count=1, setWord=0x4100000000.
REQ-035 SHALL cover: full word, confirm with game_rdy=0 for 10 cycles then 1 -> toggle_state one cycle after rdy rises, never earlier.
REQ-036 SHALL cover: LOCKED, keys ignored, game_done -> letter_count=0, setWord=0, locked=0; key_valid+key_del same cycle at count 2 -> count 1.
REQ-037 SHALL cover: nRst asserted mid-WAIT_RDY -> all outputs zero asynchronously, no toggle_state after release.
